// File: rtl/call_stack.sv
// Hardware return-address stack for the microcoded control unit.
// A call pushes {return PC, flags}; a return pops them back. The top entry is
// presented combinationally so the control unit can capture the flags on the
// same edge that performs the pop.
module call_stack #(
  parameter int PC_WIDTH  = 8,
  parameter int DEPTH     = 8,
  parameter int PTR_WIDTH = 3
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_push_en,
  input  logic                 in_pop_en,
  input  logic [PC_WIDTH-1:0]  in_pc,
  input  logic [3:0]           in_flags,
  input  logic                 in_pc_enable_out,
  output logic [PC_WIDTH-1:0]  out_pc_bus,
  output logic [PC_WIDTH-1:0]  out_top_pc,
  output logic [3:0]           out_flags,
  output logic [PTR_WIDTH:0]   out_count,
  output logic                 out_empty,
  output logic                 out_full,
  output logic                 out_overflow,
  output logic                 out_underflow
);

  localparam int               ENTRY_W  = PC_WIDTH + 4;
  localparam logic [PTR_WIDTH:0] FULL_CNT = (PTR_WIDTH + 1)'(DEPTH);

  // Entry layout: PC in the upper bits, flags in the low nibble.
  logic [ENTRY_W-1:0]   mem [DEPTH];
  logic [PTR_WIDTH:0]   sp;
  logic [PTR_WIDTH-1:0] top_idx;
  logic [PTR_WIDTH-1:0] wr_idx;
  logic                 do_write;
  logic                 empty;
  logic                 full;
  logic [ENTRY_W-1:0]   top_entry;

  assign empty   = (sp == '0);
  assign full    = (sp == FULL_CNT);
  // When sp == DEPTH the low bits wrap to 0, so subtracting one lands on DEPTH-1.
  assign top_idx = sp[PTR_WIDTH-1:0] - 1'b1;

  // Decide whether and where this cycle writes the array. A simultaneous
  // push+pop on a non-empty stack overwrites the top in place; on an empty
  // stack it degenerates to a plain push.
  always_comb begin
    do_write = 1'b0;
    wr_idx   = sp[PTR_WIDTH-1:0];
    if (!rst && in_push_en) begin
      if (in_pop_en && !empty) begin
        do_write = 1'b1;
        wr_idx   = top_idx;
      end else if (!full) begin
        do_write = 1'b1;
      end
    end
  end

  // Stack pointer and sticky error flags; reset discards the stack.
  always_ff @(posedge clk) begin
    if (rst) begin
      sp            <= '0;
      out_overflow  <= 1'b0;
      out_underflow <= 1'b0;
    end else begin
      case ({in_push_en, in_pop_en})
        2'b10: begin
          if (full) out_overflow <= 1'b1;
          else      sp           <= sp + 1'b1;
        end
        2'b01: begin
          if (empty) out_underflow <= 1'b1;
          else       sp            <= sp - 1'b1;
        end
        2'b11: begin
          // Replace-top keeps sp; only the empty case grows the stack.
          if (empty) sp <= sp + 1'b1;
        end
        default: ;
      endcase
    end
  end

  // Entry storage; contents are deliberately left untouched by reset.
  always_ff @(posedge clk) begin
    if (do_write) mem[wr_idx] <= {in_pc, in_flags};
  end

  // Zero-latency read of the current top; an empty stack reads as zero.
  assign top_entry  = empty ? '0 : mem[top_idx];
  assign out_top_pc = top_entry[ENTRY_W-1:4];
  assign out_flags  = top_entry[3:0];
  assign out_count  = sp;
  assign out_empty  = empty;
  assign out_full   = full;

  // Shared PC load bus: released whenever this block is not selected.
  assign out_pc_bus = in_pc_enable_out ? out_top_pc : {PC_WIDTH{1'bz}};

endmodule

// File: tb/tb_call_stack.sv
// Self-checking bench for call_stack: directed scenarios plus a randomized
// run against a queue-based model of a bounded LIFO.
module tb_call_stack;

  localparam int PC_WIDTH  = 8;
  localparam int DEPTH     = 8;
  localparam int PTR_WIDTH = 3;

  logic                clk = 1'b0;
  logic                rst;
  logic                in_push_en;
  logic                in_pop_en;
  logic [PC_WIDTH-1:0] in_pc;
  logic [3:0]          in_flags;
  logic                in_pc_enable_out;
  logic [PC_WIDTH-1:0] out_pc_bus;
  logic [PC_WIDTH-1:0] out_top_pc;
  logic [3:0]          out_flags;
  logic [PTR_WIDTH:0]  out_count;
  logic                out_empty;
  logic                out_full;
  logic                out_overflow;
  logic                out_underflow;

  int n_vec  = 0;
  int n_fail = 0;

  logic [PC_WIDTH-1:0] bus_z;

  call_stack #(.PC_WIDTH(PC_WIDTH), .DEPTH(DEPTH), .PTR_WIDTH(PTR_WIDTH)) dut (
    .clk(clk),
    .rst(rst),
    .in_push_en(in_push_en),
    .in_pop_en(in_pop_en),
    .in_pc(in_pc),
    .in_flags(in_flags),
    .in_pc_enable_out(in_pc_enable_out),
    .out_pc_bus(out_pc_bus),
    .out_top_pc(out_top_pc),
    .out_flags(out_flags),
    .out_count(out_count),
    .out_empty(out_empty),
    .out_full(out_full),
    .out_overflow(out_overflow),
    .out_underflow(out_underflow)
  );

  always #5 clk = ~clk;

  // Advance one edge and settle; inputs change only between edges.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_in(input logic r, input logic push, input logic pop,
                        input logic [PC_WIDTH-1:0] pc, input logic [3:0] fl);
    rst        = r;
    in_push_en = push;
    in_pop_en  = pop;
    in_pc      = pc;
    in_flags   = fl;
  endtask

  task automatic idle();
    set_in(1'b0, 1'b0, 1'b0, '0, '0);
  endtask

  task automatic do_reset();
    set_in(1'b1, 1'b0, 1'b0, '0, '0);
    tick();
    idle();
    #1;
  endtask

  task automatic push(input logic [PC_WIDTH-1:0] pc, input logic [3:0] fl);
    set_in(1'b0, 1'b1, 1'b0, pc, fl);
    tick();
    idle();
    #1;
  endtask

  task automatic test_reset();
    in_pc_enable_out = 1'b0;
    do_reset();
    n_vec++; if (out_count !== 4'd0) begin n_fail++; $display("FAIL reset_count got %0d want 0", out_count); end
    n_vec++; if (out_empty !== 1'b1) begin n_fail++; $display("FAIL reset_empty got %b want 1", out_empty); end
    n_vec++; if (out_full !== 1'b0) begin n_fail++; $display("FAIL reset_full got %b want 0", out_full); end
    n_vec++; if (out_top_pc !== 8'h00) begin n_fail++; $display("FAIL reset_top_pc got %h want 00", out_top_pc); end
    n_vec++; if (out_flags !== 4'h0) begin n_fail++; $display("FAIL reset_flags got %h want 0", out_flags); end
    n_vec++; if (out_overflow !== 1'b0) begin n_fail++; $display("FAIL reset_overflow got %b want 0", out_overflow); end
    n_vec++; if (out_underflow !== 1'b0) begin n_fail++; $display("FAIL reset_underflow got %b want 0", out_underflow); end
    n_vec++; if (out_pc_bus !== bus_z) begin n_fail++; $display("FAIL reset_bus got %h want z", out_pc_bus); end
    in_pc_enable_out = 1'b1;
    #1;
    n_vec++; if (out_pc_bus !== 8'h00) begin n_fail++; $display("FAIL reset_bus_en got %h want 00", out_pc_bus); end
    in_pc_enable_out = 1'b0;
  endtask

  task automatic test_call_return();
    do_reset();
    push(8'h12, 4'b0101);
    set_in(1'b0, 1'b0, 1'b1, '0, '0);
    #1;
    n_vec++; if (out_top_pc !== 8'h12) begin n_fail++; $display("FAIL callret_pop_pc got %h want 12", out_top_pc); end
    n_vec++; if (out_flags !== 4'b0101) begin n_fail++; $display("FAIL callret_pop_flags got %b want 0101", out_flags); end
    tick();
    idle();
    #1;
    n_vec++; if (out_count !== 4'd0) begin n_fail++; $display("FAIL callret_count got %0d want 0", out_count); end
    n_vec++; if (out_empty !== 1'b1) begin n_fail++; $display("FAIL callret_empty got %b want 1", out_empty); end
    n_vec++; if (out_flags !== 4'h0) begin n_fail++; $display("FAIL callret_flags got %h want 0", out_flags); end
  endtask

  task automatic test_lifo();
    logic [PC_WIDTH-1:0] exp_pc;
    logic [3:0]          exp_fl;
    do_reset();
    push(8'h10, 4'd1);
    push(8'h20, 4'd2);
    push(8'h30, 4'd3);
    n_vec++; if (out_count !== 4'd3) begin n_fail++; $display("FAIL lifo_count_full got %0d want 3", out_count); end
    for (int i = 3; i >= 1; i--) begin
      exp_pc = 8'(i * 16);
      exp_fl = 4'(i);
      set_in(1'b0, 1'b0, 1'b1, '0, '0);
      #1;
      n_vec++; if (out_top_pc !== exp_pc) begin n_fail++; $display("FAIL lifo_pc[%0d] got %h want %h", i, out_top_pc, exp_pc); end
      n_vec++; if (out_flags !== exp_fl) begin n_fail++; $display("FAIL lifo_flags[%0d] got %h want %h", i, out_flags, exp_fl); end
      tick();
      idle();
      #1;
      n_vec++; if (out_count !== 4'(i - 1)) begin n_fail++; $display("FAIL lifo_count[%0d] got %0d want %0d", i, out_count, i - 1); end
    end
  endtask

  task automatic test_overflow();
    do_reset();
    for (int i = 1; i <= DEPTH; i++) push(8'(i), 4'(i));
    n_vec++; if (out_overflow !== 1'b0) begin n_fail++; $display("FAIL ovf_early got %b want 0", out_overflow); end
    push(8'hFF, 4'hF);
    n_vec++; if (out_full !== 1'b1) begin n_fail++; $display("FAIL ovf_full got %b want 1", out_full); end
    n_vec++; if (out_count !== 4'd8) begin n_fail++; $display("FAIL ovf_count got %0d want 8", out_count); end
    n_vec++; if (out_top_pc !== 8'h08) begin n_fail++; $display("FAIL ovf_top got %h want 08", out_top_pc); end
    n_vec++; if (out_overflow !== 1'b1) begin n_fail++; $display("FAIL ovf_flag got %b want 1", out_overflow); end
    for (int i = DEPTH; i >= 1; i--) begin
      set_in(1'b0, 1'b0, 1'b1, '0, '0);
      #1;
      n_vec++; if (out_top_pc !== 8'(i)) begin n_fail++; $display("FAIL ovf_pop_pc[%0d] got %h want %h", i, out_top_pc, 8'(i)); end
      tick();
    end
    idle();
    #1;
    n_vec++; if (out_empty !== 1'b1) begin n_fail++; $display("FAIL ovf_drain_empty got %b want 1", out_empty); end
    n_vec++; if (out_overflow !== 1'b1) begin n_fail++; $display("FAIL ovf_sticky got %b want 1", out_overflow); end
  endtask

  task automatic test_underflow_simul();
    do_reset();
    set_in(1'b0, 1'b0, 1'b1, '0, '0);
    tick();
    idle();
    #1;
    n_vec++; if (out_underflow !== 1'b1) begin n_fail++; $display("FAIL unf_flag got %b want 1", out_underflow); end
    n_vec++; if (out_count !== 4'd0) begin n_fail++; $display("FAIL unf_count got %0d want 0", out_count); end
    push(8'h40, 4'h3);
    set_in(1'b0, 1'b1, 1'b1, 8'h50, 4'hA);
    #1;
    n_vec++; if (out_top_pc !== 8'h40) begin n_fail++; $display("FAIL repl_old_top got %h want 40", out_top_pc); end
    tick();
    idle();
    #1;
    n_vec++; if (out_count !== 4'd1) begin n_fail++; $display("FAIL repl_count got %0d want 1", out_count); end
    n_vec++; if (out_top_pc !== 8'h50) begin n_fail++; $display("FAIL repl_pc got %h want 50", out_top_pc); end
    n_vec++; if (out_flags !== 4'hA) begin n_fail++; $display("FAIL repl_flags got %h want a", out_flags); end
    set_in(1'b0, 1'b0, 1'b1, '0, '0);
    tick();
    set_in(1'b0, 1'b1, 1'b1, 8'h60, 4'h6);
    tick();
    idle();
    #1;
    n_vec++; if (out_count !== 4'd1) begin n_fail++; $display("FAIL pp_empty_count got %0d want 1", out_count); end
    n_vec++; if (out_top_pc !== 8'h60) begin n_fail++; $display("FAIL pp_empty_pc got %h want 60", out_top_pc); end
    n_vec++; if (out_underflow !== 1'b1) begin n_fail++; $display("FAIL pp_empty_unf got %b want 1", out_underflow); end
    // Simultaneous push+pop on a full stack replaces the top without overflow.
    do_reset();
    for (int i = 1; i <= DEPTH; i++) push(8'(8'h80 + i), 4'(i));
    set_in(1'b0, 1'b1, 1'b1, 8'h77, 4'h7);
    tick();
    idle();
    #1;
    n_vec++; if (out_count !== 4'd8) begin n_fail++; $display("FAIL pp_full_count got %0d want 8", out_count); end
    n_vec++; if (out_top_pc !== 8'h77) begin n_fail++; $display("FAIL pp_full_pc got %h want 77", out_top_pc); end
    n_vec++; if (out_overflow !== 1'b0) begin n_fail++; $display("FAIL pp_full_ovf got %b want 0", out_overflow); end
  endtask

  task automatic test_bus_reset();
    do_reset();
    push(8'h33, 4'h1);
    in_pc_enable_out = 1'b1;
    #1;
    n_vec++; if (out_pc_bus !== 8'h33) begin n_fail++; $display("FAIL bus_drive got %h want 33", out_pc_bus); end
    in_pc_enable_out = 1'b0;
    #1;
    n_vec++; if (out_pc_bus !== bus_z) begin n_fail++; $display("FAIL bus_release got %h want z", out_pc_bus); end
    push(8'h44, 4'h2);
    set_in(1'b1, 1'b0, 1'b1, '0, '0);
    tick();
    idle();
    #1;
    n_vec++; if (out_count !== 4'd0) begin n_fail++; $display("FAIL rstpop_count got %0d want 0", out_count); end
    n_vec++; if (out_underflow !== 1'b0) begin n_fail++; $display("FAIL rstpop_unf got %b want 0", out_underflow); end
    n_vec++; if (out_top_pc !== 8'h00) begin n_fail++; $display("FAIL rstpop_top got %h want 00", out_top_pc); end
  endtask

  task automatic test_random();
    logic [PC_WIDTH+3:0] model[$];
    logic                m_ovf;
    logic                m_unf;
    logic [PC_WIDTH-1:0] e_pc;
    logic [3:0]          e_fl;
    logic                r, p, q, en;
    logic [PC_WIDTH-1:0] pc;
    logic [3:0]          fl;
    do_reset();
    m_ovf = 1'b0;
    m_unf = 1'b0;
    for (int cyc = 0; cyc < 600; cyc++) begin
      r  = ($urandom_range(0, 59) == 0);
      p  = ($urandom_range(0, 99) < 55);
      q  = ($urandom_range(0, 99) < 45);
      en = $urandom_range(0, 1) == 1;
      pc = 8'($urandom);
      fl = 4'($urandom);
      set_in(r, p, q, pc, fl);
      in_pc_enable_out = en;
      #1;
      e_pc = (model.size() == 0) ? '0 : model[$][PC_WIDTH+3:4];
      e_fl = (model.size() == 0) ? '0 : model[$][3:0];
      n_vec++; if (out_top_pc !== e_pc) begin n_fail++; $display("FAIL rnd_pc cyc %0d got %h want %h", cyc, out_top_pc, e_pc); end
      n_vec++; if (out_flags !== e_fl) begin n_fail++; $display("FAIL rnd_flags cyc %0d got %h want %h", cyc, out_flags, e_fl); end
      n_vec++; if (out_count !== 4'(model.size())) begin n_fail++; $display("FAIL rnd_count cyc %0d got %0d want %0d", cyc, out_count, model.size()); end
      n_vec++; if (out_empty !== (model.size() == 0)) begin n_fail++; $display("FAIL rnd_empty cyc %0d got %b", cyc, out_empty); end
      n_vec++; if (out_full !== (model.size() == DEPTH)) begin n_fail++; $display("FAIL rnd_full cyc %0d got %b", cyc, out_full); end
      n_vec++; if (out_overflow !== m_ovf) begin n_fail++; $display("FAIL rnd_ovf cyc %0d got %b want %b", cyc, out_overflow, m_ovf); end
      n_vec++; if (out_underflow !== m_unf) begin n_fail++; $display("FAIL rnd_unf cyc %0d got %b want %b", cyc, out_underflow, m_unf); end
      n_vec++; if (out_pc_bus !== (en ? e_pc : bus_z)) begin n_fail++; $display("FAIL rnd_bus cyc %0d got %h en %b", cyc, out_pc_bus, en); end
      tick();
      if (r) begin
        model.delete();
        m_ovf = 1'b0;
        m_unf = 1'b0;
      end else if (p && q) begin
        if (model.size() == 0) model.push_back({pc, fl});
        else model[model.size() - 1] = {pc, fl};
      end else if (p) begin
        if (model.size() == DEPTH) m_ovf = 1'b1;
        else model.push_back({pc, fl});
      end else if (q) begin
        if (model.size() == 0) m_unf = 1'b1;
        else void'(model.pop_back());
      end
    end
    idle();
    in_pc_enable_out = 1'b0;
  endtask

  initial begin
    bus_z = {PC_WIDTH{1'bz}};
    in_pc_enable_out = 1'b0;
    set_in(1'b1, 1'b0, 1'b0, '0, '0);
    tick();
    test_reset();
    test_call_return();
    test_lifo();
    test_overflow();
    test_underflow_simul();
    test_bus_reset();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule

// File: doc/call_stack.md
Name: call_stack

Overview:
- Hardware return-address stack, directly downstream of the microcoded control unit's push_stack/pop_stack control lines.
- On a call, it saves the return PC plus the 4-bit flag register. On a return, it restores both.
- Top-of-stack flags feed the control unit's stack-flags input, which is sampled on the pop cycle.
- Top-of-stack PC is driven onto the PC load bus under a tri-state enable.

Parameters:
- PC_WIDTH, 8, width of the stored program-counter value.
- DEPTH, 8, number of stack entries; must be a power of 2, at least 2.
- PTR_WIDTH, 3, log2(DEPTH); occupancy counter is PTR_WIDTH+1 bits.

Ports:
- clk  input  1  system clock; all state updates on posedge.
- rst  input  1  synchronous, active-high reset.
- in_push_en  input  1  push {in_pc, in_flags} this cycle (control unit push_stack).
- in_pop_en  input  1  pop top entry this cycle (control unit pop_stack).
- in_pc  input  PC_WIDTH  return address to save.
- in_flags  input  4  flags to save (control unit out_flags).
- in_pc_enable_out  input  1  drive top PC onto out_pc_bus.
- out_pc_bus  output  PC_WIDTH  top PC when in_pc_enable_out=1, else high-Z.
- out_top_pc  output  PC_WIDTH  top PC, always driven; 0 when empty.
- out_flags  output  4  top flags, combinational; 0 when empty.
- out_count  output  PTR_WIDTH+1  current occupancy, 0..DEPTH.
- out_empty  output  1  count==0.
- out_full  output  1  count==DEPTH.
- out_overflow  output  1  sticky: push attempted while full.
- out_underflow  output  1  sticky: pop attempted while empty.

Behaviour:
- Storage and pointer
  - Entries are {PC_WIDTH+4} bits wide, in a register array.
  - sp = out_count. The top entry is index sp-1.
- Reset (rst=1 at posedge)
  - sp=0; out_overflow=0; out_underflow=0.
  - Array contents are not cleared.
  - Outputs after reset: out_top_pc=0, out_flags=0, out_empty=1, out_full=0, out_count=0, out_pc_bus=Z unless enabled (then 0).
  - Reset overrides push/pop in the same cycle. Reset between a push and its pop simply discards the stack.
- Read path is combinational
  - out_top_pc, out_flags and out_pc_bus reflect the current top with zero latency.
  - The control unit captures out_flags on the same edge that performs the pop. Pop therefore presents the old top during the pop cycle; the new top is visible the cycle after.
- Push only (push=1, pop=0)
  - Not full: mem[sp] <= {in_pc, in_flags}; sp <= sp+1. The new top is visible next cycle.
  - Full: no write, sp unchanged, out_overflow <= 1.
- Pop only (push=0, pop=1)
  - Not empty: sp <= sp-1.
  - Empty: sp unchanged, out_underflow <= 1, outputs stay 0.
- Push and pop together
  - Not empty: replace top: mem[sp-1] <= new entry; sp unchanged. The popped (old) top is shown during the cycle.
  - Empty: behaves as push only; no underflow flagged.
  - Full: replace top; no overflow flagged.
- Idle (neither asserted): state holds.
- Sticky errors clear only on rst.
- Width rules
  - sp is PTR_WIDTH+1 bits; array index uses sp[PTR_WIDTH-1:0].
  - sp never exceeds DEPTH and never wraps below 0.
- The tri-state bus must not be driven when in_pc_enable_out=0, so that it can share the bus with the PC and control-unit drivers.

Test Plan:
- Reset: rst=1 for 1 cycle, then idle -> count=0, empty=1, full=0, top_pc=0, flags=0, overflow=0, underflow=0; out_pc_bus=Z with enable=0.
- Call/return pair: push pc=0x12, flags=4'b0101; next cycle pop -> during pop cycle top_pc=0x12, flags=0101; after edge count=0, empty=1, flags=0.
- LIFO nesting: push 0x10/1, 0x20/2, 0x30/3, then 3 pops -> tops seen in pop cycles 0x30/3, 0x20/2, 0x10/1; count goes 3,2,1,0.
- Overflow: 8 pushes of 0x01..0x08, then 9th push 0xFF -> full=1, count=8, top stays 0x08, overflow=1. Then 8 pops return 0x08..0x01 and overflow stays 1.
- Underflow and simultaneous ops:
  - Pop on empty -> underflow=1, count=0.
  - Push 0x40 then push+pop with 0x50/4'hA -> count=1, top=0x50, flags=A.
  - Push+pop on empty with 0x60 -> count=1, top=0x60, underflow unchanged.
- Bus and reset mid-stack: push 0x33; enable_out=1 -> out_pc_bus=0x33; enable_out=0 -> Z. Push 0x44, then rst together with pop -> count=0, underflow=0, top_pc=0.
